// File: rtl/jt89_regs_if.sv
// CPU write bus of the jt89 PSG: data byte, active-low strobe and ready.
interface jt89_regs_if;
    logic [7:0] din;
    logic       wr_n;
    logic       ready;

    modport master (output din, output wr_n, input  ready);
    modport slave  (input  din, input  wr_n, output ready);
endinterface

// File: rtl/jt89_regs.sv
// jt89_regs: SN76489-compatible PSG register file and CPU write decoder.
// Optional build macro JT89_REGS_DATAVOL_EN: data bytes also update a latched
// volume or noise register (SMS VDP variant); otherwise they are ignored.
module jt89_regs #(
    parameter int unsigned BUSY_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en_i,
    jt89_regs_if.slave        bus,
    output logic [9:0]        tone0_o,
    output logic [9:0]        tone1_o,
    output logic [9:0]        tone2_o,
    output logic [3:0]        vol0_o,
    output logic [3:0]        vol1_o,
    output logic [3:0]        vol2_o,
    output logic [3:0]        vol3_o,
    output logic [2:0]        ctrl3_o,
    output logic              noise_rst_o
);

    localparam int unsigned    CNT_W     = 8;
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);
    localparam logic [1:0]     CH_NOISE  = 2'd3;

    logic [9:0]       tone0_q, tone1_q, tone2_q, tone0_d, tone1_d, tone2_d;
    logic [3:0]       vol0_q, vol1_q, vol2_q, vol3_q;
    logic [3:0]       vol0_d, vol1_d, vol2_d, vol3_d;
    logic [2:0]       ctrl3_q, ctrl3_d;
    logic             noise_rst_q, noise_rst_d;
    logic [1:0]       ch_q, ch_d;
    logic             typ_q, typ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             wr_l_q, wr_l_d;
    logic             accept;

    // Register update; rst wins over any write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone0_q     <= 10'd0;
            tone1_q     <= 10'd0;
            tone2_q     <= 10'd0;
            vol0_q      <= 4'hF;
            vol1_q      <= 4'hF;
            vol2_q      <= 4'hF;
            vol3_q      <= 4'hF;
            ctrl3_q     <= 3'd0;
            noise_rst_q <= 1'b0;
            ch_q        <= 2'd0;
            typ_q       <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            wr_l_q      <= 1'b1;
        end else begin
            tone0_q     <= tone0_d;
            tone1_q     <= tone1_d;
            tone2_q     <= tone2_d;
            vol0_q      <= vol0_d;
            vol1_q      <= vol1_d;
            vol2_q      <= vol2_d;
            vol3_q      <= vol3_d;
            ctrl3_q     <= ctrl3_d;
            noise_rst_q <= noise_rst_d;
            ch_q        <= ch_d;
            typ_q       <= typ_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            wr_l_q      <= wr_l_d;
        end
    end

    // Write decode: one write per wr_n falling edge, only while ready.
    always_comb begin
        tone0_d     = tone0_q;
        tone1_d     = tone1_q;
        tone2_d     = tone2_q;
        vol0_d      = vol0_q;
        vol1_d      = vol1_q;
        vol2_d      = vol2_q;
        vol3_d      = vol3_q;
        ctrl3_d     = ctrl3_q;
        noise_rst_d = 1'b0;
        ch_d        = ch_q;
        typ_d       = typ_q;
        cnt_d       = cnt_q;
        wr_l_d      = bus.wr_n;
        accept      = wr_l_q & ~bus.wr_n & ready_q;

        if (clk_en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (accept) begin
            cnt_d = BUSY_LOAD;
            if (bus.din[7]) begin
                // Latch byte: select register and write its low nibble.
                ch_d  = bus.din[6:5];
                typ_d = bus.din[4];
                if (bus.din[4]) begin
                    case (bus.din[6:5])
                        2'd0:    vol0_d = bus.din[3:0];
                        2'd1:    vol1_d = bus.din[3:0];
                        2'd2:    vol2_d = bus.din[3:0];
                        default: vol3_d = bus.din[3:0];
                    endcase
                end else begin
                    case (bus.din[6:5])
                        2'd0:    tone0_d[3:0] = bus.din[3:0];
                        2'd1:    tone1_d[3:0] = bus.din[3:0];
                        2'd2:    tone2_d[3:0] = bus.din[3:0];
                        default: begin
                            ctrl3_d     = bus.din[2:0];
                            noise_rst_d = 1'b1;
                        end
                    endcase
                end
            end else begin
                // Data byte: upper tone bits of the latched channel.
                if (!typ_q && ch_q != CH_NOISE) begin
                    case (ch_q)
                        2'd0:    tone0_d[9:4] = bus.din[5:0];
                        2'd1:    tone1_d[9:4] = bus.din[5:0];
                        default: tone2_d[9:4] = bus.din[5:0];
                    endcase
                end
`ifdef JT89_REGS_DATAVOL_EN
                else if (typ_q) begin
                    case (ch_q)
                        2'd0:    vol0_d = bus.din[3:0];
                        2'd1:    vol1_d = bus.din[3:0];
                        2'd2:    vol2_d = bus.din[3:0];
                        default: vol3_d = bus.din[3:0];
                    endcase
                end else begin
                    ctrl3_d     = bus.din[2:0];
                    noise_rst_d = 1'b1;
                end
`endif
            end
        end

        ready_d = (cnt_d == '0);
    end

    assign bus.ready   = ready_q;
    assign tone0_o     = tone0_q;
    assign tone1_o     = tone1_q;
    assign tone2_o     = tone2_q;
    assign vol0_o      = vol0_q;
    assign vol1_o      = vol1_q;
    assign vol2_o      = vol2_q;
    assign vol3_o      = vol3_q;
    assign ctrl3_o     = ctrl3_q;
    assign noise_rst_o = noise_rst_q;

endmodule
